// File: rtl/tcgrom_arbiter.sv
// Round-robin arbiter sharing the combinational character-ROM read port between glyph renderers.
// Grant and ROM address are registered; the row bitmap returns tagged to its winner one cycle later.
module tcgrom_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   output logic [N_REQ-1:0]          gnt,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data,
   output logic [N_REQ-1:0]          rd_valid,
   output logic [DATA_W-1:0]         rd_data
);

   localparam int PTR_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] tag;
   logic             vld1;
   logic [N_REQ-1:0] eff;
   logic [N_REQ-1:0] rot;
   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] win;
   logic             win_vld;

   // rot[k] is the request k places after ptr; scanning k downward leaves the nearest one.
   always_comb begin
      eff     = req & ~gnt;
      rot     = N_REQ'({eff, eff} >> ptr);
      sum     = '0;
      win     = '0;
      win_vld = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_REQ)) begin
               sum = sum - (PTR_W+1)'(N_REQ);
            end
            win     = sum[PTR_W-1:0];
            win_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt      <= '0;
         rom_addr <= '0;
         tag      <= '0;
         vld1     <= 1'b0;
         ptr      <= '0;
      end else if (win_vld) begin
         gnt      <= ONE << win;
         rom_addr <= req_addr[win*ADDR_W +: ADDR_W];
         tag      <= win;
         vld1     <= 1'b1;
         ptr      <= (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end else begin
         gnt      <= '0;
         vld1     <= 1'b0;
      end
   end

   // Return stage: rom_addr has been stable for a full cycle, so rom_data belongs to tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= '0;
         rd_data  <= '0;
      end else begin
         rd_valid <= vld1 ? (ONE << tag) : '0;
         if (vld1) begin
            rd_data <= rom_data;
         end
      end
   end

endmodule

// File: doc/tcgrom_arbiter.md
# tcgrom_arbiter

Round-robin arbiter that shares one character-ROM (`tcgrom`) read port between several glyph renderers (digit, colon and label displays) on the scoreboard video path. Each renderer posts a 9-bit row address. The arbiter grants one requester per cycle, drives the ROM address from a register, and returns the 8-bit row bitmap tagged to the winner two cycles after the request is sampled. The ROM stays combinational; all sequencing lives in this block.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `ADDR_W`, default 9: ROM address width.
- `DATA_W`, default 8: ROM row width.

Ports:
- `clk`, input, 1: single clock for all logic.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, N_REQ: request per requester. Level; held until granted.
- `req_addr`, input, N_REQ*ADDR_W: packed addresses. Requester i uses bits [i*ADDR_W +: ADDR_W]. Must be stable while `req[i]` is high.
- `gnt`, output, N_REQ: one-hot grant, registered, one-cycle pulse.
- `rom_addr`, output, ADDR_W: registered address to `tcgrom.addr`.
- `rom_data`, input, DATA_W: combinational `tcgrom.data` for `rom_addr`.
- `rd_valid`, output, N_REQ: one-hot return strobe, one-cycle pulse.
- `rd_data`, output, DATA_W: returned row bitmap. Valid when any `rd_valid` bit is set; otherwise holds its last value.

## Operation
- Priority pointer `ptr` (0..N_REQ-1) names the highest-priority requester.
- Effective requests: `eff = req & ~gnt`. A requester granted this cycle is masked out, so one held `req` cannot win twice back to back through its grant cycle.
- Winner: the first set bit of `eff` scanning `ptr`, `ptr+1`, … mod N_REQ.
- On each edge with a winner w:
  - `gnt <= onehot(w)`
  - `rom_addr <= req_addr[w]`
  - `tag <= w`
  - `vld1 <= 1`
  - `ptr <= (w == N_REQ-1) ? 0 : w+1`
- On each edge with no winner: `gnt <= 0`, `vld1 <= 0`. `rom_addr`, `tag` and `ptr` hold.
- Return stage, every edge:
  - `rd_valid <= vld1 ? onehot(tag) : 0`
  - if `vld1`: `rd_data <= rom_data`
- Requester protocol:
  - Keep `req`/`addr` until the cycle `gnt[i]` is seen.
  - To issue another read, present the new address with `req` still high in the cycle after `gnt`. That counts as a fresh request.
  - Dropping `req` before it is granted withdraws the request with no side effects.
- Fairness: with N_REQ requesters all active, each is granted at least once every N_REQ cycles. Throughput is one read per cycle.

## Timing
- Reset values (async assert, sync deassert by system): `gnt`=0, `rom_addr`=0, `rd_valid`=0, `rd_data`=0, `ptr`=0, `tag`=0, `vld1`=0.
- Latency, with the request sampled at edge E0:
  - `gnt` and `rom_addr` are valid in the cycle after E0.
  - `rd_valid`/`rd_data` are valid in the cycle after E1.
  - Request to data is 2 cycles.
- Fully pipelined: a new grant may issue every cycle while the previous return is in flight.
- Reset mid-operation clears all in-flight reads. No `rd_valid` is produced for a read granted before reset.
- `ptr` wraps from N_REQ-1 to 0.
- Simultaneous request and withdrawal is resolved on the sampled `req` value only.

## Test plan
- Single request: `req`=4'b0001, addr 9'h138, asserted at edge 0.
  - Required: `gnt`=4'b0001 after edge 1, `rom_addr`=9'h138.
  - Required: `rd_valid`=4'b0001 after edge 2, `rd_data` = ROM row 0x138.
- All requesters held: `req`=4'b1111 continuously, distinct addresses.
  - Required: `gnt` sequence 0001, 0010, 0100, 1000, 0001…
  - Required: each `rd_valid` returns the matching address's data two cycles after its grant.
  - Required: no idle cycles.
- Wrap and skip: `req`=4'b1010 held.
  - Required: grants alternate 0010, 1000.
  - Required: after the grant to requester 3, `ptr`=0 and the next grant is requester 1.
- Withdrawal: `req[2]` raised for one cycle while `req[0]` holds and `ptr`=0.
  - Required: requester 0 wins; requester 2 is never granted; no `rd_valid[2]`.
- Reset in flight: assert `rst_n`=0 in the cycle `gnt` is high.
  - Required: `gnt`, `rd_valid`, `rd_data` and `rom_addr` are 0 immediately.
  - Required: no `rd_valid` after release.
  - Required: the first post-reset grant goes to requester 0 when all four request.
